// File: rtl/uart_pkg.sv
// Shared UART definitions: runtime format encodings, the receiver state type
// and the oversample divisor helper. Imported by uart_rx, uart_baud_tick and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_e;

  // 2'b11 is a second encoding of "no parity" so both uart_tx and uart_rx agree.
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } rx_state_e;

  // Width of the clock-to-oversample-tick divisor; covers 50 MHz at 2400 baud.
  localparam int unsigned DIV_W = 16;

  function automatic int unsigned baudHz(input baud_e baudSel);
    int unsigned hz;
    case (baudSel)
      BAUD_2400:  hz = 2400;
      BAUD_4800:  hz = 4800;
      BAUD_9600:  hz = 9600;
      BAUD_19200: hz = 19200;
      default:    hz = 9600;
    endcase
    return hz;
  endfunction

  // Rounded clock count per oversample tick: round(clkFreq / (baud * oversample)).
  function automatic logic [DIV_W-1:0] divisor(input int unsigned clkFreq,
                                               input baud_e       baudSel,
                                               input int unsigned oversample);
    int unsigned denom;
    denom = baudHz(baudSel) * oversample;
    return DIV_W'((clkFreq + denom / 2) / denom);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts system clocks up to the selected divisor
// and emits a one-clock tick. A restart pulse zeroes the count so ticks stay
// phase-aligned with the detected start edge.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;
  logic             r_tick;

  // Free-running divisor counter, restarted on reset or on a start edge.
  always_ff @(posedge clock) begin
    if (rst || i_restart) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (r_count == i_divisor - DIV_W'(1)) begin
      r_count <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_count <= r_count + DIV_W'(1);
      r_tick  <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 7/8 data bits, optional odd/even parity
// and one or two stop bits. Format inputs are latched at each start edge.
// Build option: define UART_RX_MAJORITY_EN to resolve every bit with a 2-of-3
// vote over the samples around mid-bit; otherwise the centre sample is used.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);

  // Tick-count values seen on the arriving tick: centre is tick OVERSAMPLE/2,
  // the bit is resolved on the following tick in both builds.
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_CENTER = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LATE   = TICK_W'(OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TICK_W-1:0] TICK_EARLY  = TICK_W'(OVERSAMPLE / 2 - 2);
`endif

  localparam logic [DIV_W-1:0] DIV_2400  = divisor(CLK_FREQ, BAUD_2400, OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_4800  = divisor(CLK_FREQ, BAUD_4800, OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_9600  = divisor(CLK_FREQ, BAUD_9600, OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_19200 = divisor(CLK_FREQ, BAUD_19200, OVERSAMPLE);

  rx_state_e         r_state;
  rx_state_e         w_stateNext;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_syncPrev;
  logic              w_line;
  logic              w_startEdge;

  baud_e             r_baud;
  parity_e           r_parity;
  logic              r_stop2;
  logic              r_data8;

  logic [DIV_W-1:0]  w_divisor;
  logic              w_tick;
  logic              w_restart;
  logic [TICK_W-1:0] r_tickCnt;

  logic              r_sCenter;
`ifdef UART_RX_MAJORITY_EN
  logic              r_sEarly;
`endif
  logic              w_decide;
  logic              w_bit;

  logic [7:0]        r_shift;
  logic [2:0]        r_bitIdx;
  logic              r_parAcc;
  logic              r_parErr;
  logic              r_frameErr;

  logic              w_hasParity;
  logic              w_lastData;
  logic              w_lastStop;

  // Two-flop synchronizer plus one history flop for falling-edge detection; idle high.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
    end else begin
      r_sync1    <= rx_in;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  assign w_line      = r_sync2;
  // An edge is required, so a line held low after a break cannot start a frame.
  assign w_startEdge = r_syncPrev & ~r_sync2;

  // Oversample divisor for the format latched at the current start bit.
  always_comb begin
    w_divisor = DIV_9600;
    unique case (r_baud)
      BAUD_2400:  w_divisor = DIV_2400;
      BAUD_4800:  w_divisor = DIV_4800;
      BAUD_9600:  w_divisor = DIV_9600;
      BAUD_19200: w_divisor = DIV_19200;
    endcase
  end

  uart_baud_tick u_baudTick (
    .clock     (clock),
    .rst       (rst),
    .i_restart (w_restart),
    .i_divisor (w_divisor),
    .o_tick    (w_tick)
  );

  // Latch the frame format at the start edge and count ticks within each bit.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_baud    <= BAUD_2400;
      r_parity  <= PAR_NONE;
      r_stop2   <= 1'b0;
      r_data8   <= 1'b0;
      r_tickCnt <= '0;
    end else if (w_restart) begin
      r_baud    <= baud_e'(baud_rate);
      r_parity  <= parity_e'(parity_type);
      r_stop2   <= stop_bits;
      r_data8   <= data_length;
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= (r_tickCnt == TICK_LAST) ? '0 : r_tickCnt + TICK_W'(1);
    end
  end

  // Capture the line at the mid-bit sample point(s).
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sCenter <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      r_sEarly  <= 1'b1;
`endif
    end else if (w_tick) begin
      if (r_tickCnt == TICK_CENTER) r_sCenter <= w_line;
`ifdef UART_RX_MAJORITY_EN
      if (r_tickCnt == TICK_EARLY) r_sEarly <= w_line;
`endif
    end
  end

  assign w_decide = w_tick && (r_tickCnt == TICK_LATE);

`ifdef UART_RX_MAJORITY_EN
  assign w_bit = (r_sEarly & r_sCenter) | (r_sEarly & w_line) | (r_sCenter & w_line);
`else
  assign w_bit = r_sCenter;
`endif

  assign w_hasParity = (r_parity == PAR_ODD) || (r_parity == PAR_EVEN);
  assign w_lastData  = (r_bitIdx == (r_data8 ? 3'd7 : 3'd6));
  assign w_lastStop  = !r_stop2 || (r_bitIdx == 3'd1);

  // State register.
  always_ff @(posedge clock) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  // Next-state logic and the Moore status outputs.
  always_comb begin
    w_stateNext = r_state;
    w_restart   = 1'b0;
    rx_active   = 1'b0;
    rx_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_startEdge) begin
          w_stateNext = ST_START;
          w_restart   = 1'b1;
        end
      end
      ST_START: begin
        if (w_decide) w_stateNext = w_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        rx_active = 1'b1;
        if (w_decide && w_lastData) w_stateNext = w_hasParity ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        rx_active = 1'b1;
        if (w_decide) w_stateNext = ST_STOP;
      end
      ST_STOP: begin
        rx_active = 1'b1;
        if (w_decide && w_lastStop) w_stateNext = ST_DONE;
      end
      ST_DONE: begin
        rx_done     = 1'b1;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Frame datapath: shift data, accumulate parity and stop status, and publish
  // the result on the edge entering DONE so it is valid alongside rx_done.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_shift      <= '0;
      r_bitIdx     <= '0;
      r_parAcc     <= 1'b0;
      r_parErr     <= 1'b0;
      r_frameErr   <= 1'b0;
      data_out     <= '0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else if (w_decide) begin
      case (r_state)
        ST_START: begin
          r_shift    <= '0;
          r_bitIdx   <= '0;
          r_parAcc   <= 1'b0;
          r_parErr   <= 1'b0;
          r_frameErr <= 1'b0;
        end
        ST_DATA: begin
          r_shift  <= {w_bit, r_shift[7:1]};
          r_parAcc <= r_parAcc ^ w_bit;
          r_bitIdx <= w_lastData ? 3'd0 : r_bitIdx + 3'd1;
        end
        ST_PARITY: begin
          r_parErr <= r_parAcc ^ w_bit ^ (r_parity == PAR_ODD);
        end
        ST_STOP: begin
          if (w_lastStop) begin
            data_out     <= r_data8 ? r_shift : {1'b0, r_shift[7:1]};
            parity_error <= r_parErr;
            frame_error  <= r_frameErr | ~w_bit;
          end else begin
            r_frameErr <= r_frameErr | ~w_bit;
            r_bitIdx   <= r_bitIdx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The system clock runs at 50 MHz, while the
// CLK_FREQ parameter is scaled down so each frame spans only a few hundred clocks.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ_TB   = 614_400;
  localparam int unsigned OVERSAMPLE_TB = 16;

  logic       clock = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       frame_error;

  typedef struct {
    logic [7:0] data;
    logic       parErr;
    logic       frameErr;
    string      name;
  } expect_t;

  expect_t expQ[$];
  expect_t monExp;
  int      compared   = 0;
  int      mismatched = 0;
  int      doneCount  = 0;

  always #10 clock = ~clock;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ_TB),
    .OVERSAMPLE (OVERSAMPLE_TB)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .rx_in        (rx_in),
    .baud_rate    (baud_rate),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_out     (data_out),
    .rx_active    (rx_active),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .frame_error  (frame_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  function automatic int unsigned bitClocks(input logic [1:0] baudSel);
    int unsigned hz;
    case (baudSel)
      2'b00:   hz = 2400;
      2'b01:   hz = 4800;
      2'b10:   hz = 9600;
      default: hz = 19200;
    endcase
    return (CLK_FREQ_TB / (hz * OVERSAMPLE_TB)) * OVERSAMPLE_TB;
  endfunction

  task automatic driveBit(input logic value, input int unsigned clocks);
    rx_in = value;
    repeat (clocks) @(negedge clock);
  endtask

  // Serialise one frame onto rx_in and queue the hand-computed expected result.
  task automatic applyStimulus(input string name, input logic [7:0] data, input logic [1:0] baud,
                               input logic [1:0] par, input logic stop2, input logic data8,
                               input logic flipParity, input logic lowStop2,
                               input logic [7:0] expData, input logic expPe, input logic expFe);
    expect_t     e;
    int unsigned clks;
    int          nBits;
    logic        ones;
    logic        parBit;
    e.data     = expData;
    e.parErr   = expPe;
    e.frameErr = expFe;
    e.name     = name;
    expQ.push_back(e);
    baud_rate   = baud;
    parity_type = par;
    stop_bits   = stop2;
    data_length = data8;
    clks  = bitClocks(baud);
    nBits = data8 ? 8 : 7;
    ones  = 1'b0;
    @(negedge clock);
    driveBit(1'b0, clks);
    for (int i = 0; i < nBits; i++) begin
      driveBit(data[i], clks);
      ones = ones ^ data[i];
    end
    if (par == 2'b01 || par == 2'b10) begin
      parBit = (par == 2'b01) ? ~ones : ones;
      driveBit(parBit ^ flipParity, clks);
    end
    driveBit(1'b1, clks);
    if (stop2) driveBit(~lowStop2, clks);
    driveBit(1'b1, 2 * clks);
  endtask

  // Monitor: every rx_done strobe is matched against the oldest queued expectation.
  always @(negedge clock) begin
    if (rx_done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedDone: got rx_done with data_out %0h, required no strobe", data_out);
      end else begin
        monExp = expQ.pop_front();
        checkOutput({monExp.name, ".data_out"}, 32'(data_out), 32'(monExp.data));
        checkOutput({monExp.name, ".parity_error"}, 32'(parity_error), 32'(monExp.parErr));
        checkOutput({monExp.name, ".frame_error"}, 32'(frame_error), 32'(monExp.frameErr));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    repeat (40000) @(negedge clock);
    mismatched++;
    $display("[TB] FAIL watchdog: run exceeded 40000 clocks, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rst         = 1'b1;
    rx_in       = 1'b1;
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    data_length = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("reset.data_out", 32'(data_out), 32'h00);
    checkOutput("reset.rx_active", 32'(rx_active), 32'h0);
    checkOutput("reset.rx_done", 32'(rx_done), 32'h0);
    checkOutput("reset.parity_error", 32'(parity_error), 32'h0);
    checkOutput("reset.frame_error", 32'(frame_error), 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clock);

    $display("[TB] T1: 0xAA, 9600, odd parity, 1 stop, 8-bit");
    applyStimulus("T1", 8'hAA, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0);

    $display("[TB] T2: 0x55, 19200, even parity, 2 stop, 7-bit");
    applyStimulus("T2", 8'h55, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);

    $display("[TB] T3: 0x3C, odd parity with the parity bit inverted");
    applyStimulus("T3", 8'h3C, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
    repeat (100) @(negedge clock);
    checkOutput("T3.parity_error_held", 32'(parity_error), 32'h1);

    $display("[TB] T4: second stop bit forced low");
    applyStimulus("T4err", 8'hA5, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);

    $display("[TB] T5: 100-clock glitch on the idle line at 2400 baud");
    baud_rate   = 2'b00;
    parity_type = 2'b00;
    @(negedge clock);
    rx_in = 1'b0;
    repeat (50) @(negedge clock);
    checkOutput("T5.rx_active_in_glitch", 32'(rx_active), 32'h0);
    repeat (50) @(negedge clock);
    rx_in = 1'b1;
    repeat (400) @(negedge clock);
    checkOutput("T5.rx_active_after", 32'(rx_active), 32'h0);
    checkOutput("T5.frame_error_kept", 32'(frame_error), 32'h1);
    checkOutput("T5.parity_error_kept", 32'(parity_error), 32'h0);
    checkOutput("T5.data_out_kept", 32'(data_out), 32'hA5);

    applyStimulus("T4clean", 8'h81, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);

    $display("[TB] T6: reset in the middle of DATA, then 0xF0");
    baud_rate   = 2'b10;
    parity_type = 2'b00;
    stop_bits   = 1'b0;
    data_length = 1'b1;
    @(negedge clock);
    driveBit(1'b0, bitClocks(2'b10));
    driveBit(1'b1, bitClocks(2'b10));
    driveBit(1'b0, bitClocks(2'b10));
    driveBit(1'b0, bitClocks(2'b10));
    checkOutput("T6.rx_active_mid_data", 32'(rx_active), 32'h1);
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("T6.reset.data_out", 32'(data_out), 32'h00);
    checkOutput("T6.reset.rx_active", 32'(rx_active), 32'h0);
    checkOutput("T6.reset.rx_done", 32'(rx_done), 32'h0);
    checkOutput("T6.reset.parity_error", 32'(parity_error), 32'h0);
    checkOutput("T6.reset.frame_error", 32'(frame_error), 32'h0);
    rst = 1'b0;
    repeat (2 * bitClocks(2'b10)) @(negedge clock);
    applyStimulus("T6", 8'hF0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);

    for (int i = 0; i < 2000 && expQ.size() != 0; i++) @(negedge clock);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("rx_done_count", 32'(doneCount), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
